// File: rtl/flag_branch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit_if
// Description : EX-stage flag-write signals and ID branch-request handshake
//               of the flag/branch unit. master = pipeline side,
//               slave = flag_branch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface flag_branch_unit_if #(
    parameter int DW = 16
) ();
    // EX stage flag write
    logic          ex_valid;
    logic [DW-1:0] alu_out;
    logic          alu_ovfl;
    logic          zero_en;
    logic          ovfl_en;
    logic          neg_en;
    logic          flush;
    // ID branch request
    logic          br_valid;
    logic [2:0]    br_ccc;
    logic          br_stall;
    logic          br_done;
    logic          br_taken;
    // Flag register contents
    logic          flag_z;
    logic          flag_v;
    logic          flag_n;

    modport master (
        output ex_valid, alu_out, alu_ovfl, zero_en, ovfl_en, neg_en, flush,
        output br_valid, br_ccc,
        input  br_stall, br_done, br_taken, flag_z, flag_v, flag_n
    );

    modport slave (
        input  ex_valid, alu_out, alu_ovfl, zero_en, ovfl_en, neg_en, flush,
        input  br_valid, br_ccc,
        output br_stall, br_done, br_taken, flag_z, flag_v, flag_n
    );
endinterface
`default_nettype wire

// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit
// Description : Z/V/N flag register plus 3-bit branch-condition resolver with
//               stall/done handshake towards ID and flag-hazard detection.
//               Optional macro FLAG_FWD_EN: forward in-flight EX flag values
//               into resolution instead of stalling on a hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_branch_unit #(
    parameter int DW = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    flag_branch_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    logic   z_q, v_q, n_q;
    logic   z_d, v_d, n_d;
    logic   taken_q;
    logic   done_q;

    logic   w_wr;
    logic   w_haz;
    logic   w_stall;
    logic   w_rz, w_rv, w_rn;
    logic   w_cond;

    // A flag write only happens for a live, unflushed EX instruction.
    assign w_wr  = bus.ex_valid & ~bus.flush;
    assign w_haz = w_wr & (bus.zero_en | bus.ovfl_en | bus.neg_en);

    // Next flag values: each flag changes only under its own enable.
    always_comb begin
        z_d = z_q;
        v_d = v_q;
        n_d = n_q;
        if (w_wr && bus.zero_en) z_d = (bus.alu_out == '0);
        if (w_wr && bus.ovfl_en) v_d = bus.alu_ovfl;
        if (w_wr && bus.neg_en)  n_d = bus.alu_out[DW-1];
    end

`ifdef FLAG_FWD_EN
    // Forwarded flags are exactly the next-state values, so no stall is needed.
    assign w_rz    = z_d;
    assign w_rv    = v_d;
    assign w_rn    = n_d;
    assign w_stall = 1'b0;
`else
    // Resolve from the register; a pending flag write forces a wait instead.
    assign w_rz    = z_q;
    assign w_rv    = v_q;
    assign w_rn    = n_q;
    assign w_stall = w_haz;
`endif

    // Branch condition evaluation on the selected flag set.
    always_comb begin
        w_cond = 1'b1;
        case (bus.br_ccc)
            3'b000:  w_cond = ~w_rz;
            3'b001:  w_cond = w_rz;
            3'b010:  w_cond = ~w_rz & ~w_rn;
            3'b011:  w_cond = w_rn;
            3'b100:  w_cond = w_rz | ~w_rn;
            3'b101:  w_cond = w_rz | w_rn;
            3'b110:  w_cond = w_rv;
            default: w_cond = 1'b1;
        endcase
    end

    // Flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            z_q <= z_d;
            v_q <= v_d;
            n_q <= n_d;
        end
    end

    // Branch handshake FSM; IDLE and WAIT react identically to a request,
    // WAIT just records that a hazard is being waited out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            taken_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_WAIT: begin
                    if (bus.flush || !bus.br_valid) begin
                        state_q <= S_IDLE;
                    end else if (w_stall) begin
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        taken_q <= w_cond;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.br_stall = bus.br_valid & (state_q != S_DONE);
    assign bus.br_done  = done_q;
    assign bus.br_taken = taken_q;
    assign bus.flag_z   = z_q;
    assign bus.flag_v   = v_q;
    assign bus.flag_n   = n_q;

endmodule
`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_branch_unit
// Description : Scoreboard bench for flag_branch_unit: directed scenarios
//               followed by random traffic, checked against a cycle-level
//               reference model of the flags and the branch handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_branch_unit;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flag_branch_unit_if #(.DW(DW)) bus ();

    flag_branch_unit #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic done;
        logic taken;
        logic stall;
        logic z;
        logic v;
        logic n;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: architectural flags, last resolution, and
    // whether the current cycle is the one-cycle done pulse.
    logic m_z = 1'b0, m_v = 1'b0, m_n = 1'b0, m_taken = 1'b0, m_indone = 1'b0;

    function automatic logic cond(input logic [2:0] c, input logic z, v, n);
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return z || n;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string name, input logic act, input logic expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
        end
    endtask

    // One clock cycle of stimulus: apply inputs, queue this cycle's expected
    // outputs, then advance the model to the next cycle.
    task automatic drive(input logic rst, input logic ex, input logic [DW-1:0] alu,
                         input logic ovfl, input logic ze, input logic ve,
                         input logic ne, input logic fl, input logic bv,
                         input logic [2:0] ccc);
        exp_t e;
        logic wr, haz, acc, res, fz, fv, fn, rz, rv, rn;
        @(posedge clk);
        #1;
        rst_n        = rst;
        bus.ex_valid = ex;
        bus.alu_out  = alu;
        bus.alu_ovfl = ovfl;
        bus.zero_en  = ze;
        bus.ovfl_en  = ve;
        bus.neg_en   = ne;
        bus.flush    = fl;
        bus.br_valid = bv;
        bus.br_ccc   = ccc;
        if (!rst) begin
            m_z = 0; m_v = 0; m_n = 0; m_taken = 0; m_indone = 0;
        end
        e.done  = m_indone;
        e.taken = m_taken;
        e.stall = bv && !m_indone;
        e.z     = m_z;
        e.v     = m_v;
        e.n     = m_n;
        exp_q.push_back(e);
        if (rst) begin
            wr  = ex && !fl;
            haz = wr && (ze || ve || ne);
            fz  = (wr && ze) ? (alu == 0) : m_z;
            fv  = (wr && ve) ? ovfl : m_v;
            fn  = (wr && ne) ? alu[DW-1] : m_n;
            acc = bv && !fl && !m_indone;
`ifdef FLAG_FWD_EN
            res = acc;
            rz = fz; rv = fv; rn = fn;
`else
            res = acc && !haz;
            rz = m_z; rv = m_v; rn = m_n;
`endif
            if (res) m_taken = cond(ccc, rz, rv, rn);
            m_indone = res;
            m_z = fz; m_v = fv; m_n = fn;
        end
    endtask

    task automatic idle(input logic bv, input logic [2:0] ccc);
        drive(1, 0, '0, 0, 0, 0, 0, 0, bv, ccc);
    endtask

    // Monitor: compare every sampled cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("br_done",  bus.br_done,  e.done);
                chk("br_taken", bus.br_taken, e.taken);
                chk("br_stall", bus.br_stall, e.stall);
                chk("flag_z",   bus.flag_z,   e.z);
                chk("flag_v",   bus.flag_v,   e.v);
                chk("flag_n",   bus.flag_n,   e.n);
            end
        end
    end

    initial begin
        logic bv, ex, fl;
        logic [2:0] ccc;
        logic [DW-1:0] alu;
        bus.ex_valid = 0; bus.alu_out = '0; bus.alu_ovfl = 0; bus.zero_en = 0;
        bus.ovfl_en = 0; bus.neg_en = 0; bus.flush = 0; bus.br_valid = 0;
        bus.br_ccc = '0;

        // Reset state
        repeat (3) drive(0, 0, '0, 0, 0, 0, 0, 0, 0, 3'd0);
        // Zero write sets Z only
        drive(1, 1, 16'h0000, 0, 1, 0, 0, 0, 0, 3'd0);
        idle(0, 3'd0);
        // Clear Z, then GT with no hazard: latency 1, taken
        drive(1, 1, 16'h0001, 0, 1, 0, 0, 0, 0, 3'd0);
        idle(1, 3'd2);
        idle(1, 3'd2);
        idle(0, 3'd2);
        // EQ with SUB (result 0, all enables) in EX: hazard
        drive(1, 1, 16'h0000, 1, 1, 1, 1, 0, 1, 3'd1);
        idle(1, 3'd1);
        idle(1, 3'd1);
        idle(0, 3'd1);
        // Set N, then XOR-like write of Z only with 0x8000
        drive(1, 1, 16'h8000, 0, 0, 0, 1, 0, 0, 3'd0);
        drive(1, 1, 16'h8000, 0, 1, 0, 0, 0, 0, 3'd0);
        idle(0, 3'd0);
        // Enter WAIT, then flush: no done, flag write killed
        drive(1, 1, 16'h0000, 1, 1, 1, 1, 0, 1, 3'd6);
        drive(1, 1, 16'h0000, 1, 1, 1, 1, 1, 1, 3'd6);
        idle(0, 3'd6);
        idle(0, 3'd6);
        // Enter WAIT, then asynchronous reset mid-cycle
        drive(1, 1, 16'h1234, 1, 1, 1, 1, 0, 1, 3'd7);
        drive(0, 0, '0, 0, 0, 0, 0, 0, 1, 3'd7);
        idle(0, 3'd7);
        idle(1, 3'd7);
        idle(0, 3'd7);

        // Random traffic with a protocol-respecting branch requester
        bv = 0; ccc = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(bv && !bus.br_done && ($urandom_range(0, 7) != 0))) begin
                bv  = ($urandom_range(0, 1) == 1);
                ccc = 3'($urandom_range(0, 7));
            end
            ex  = ($urandom_range(0, 1) == 1);
            fl  = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       alu = '0;
                1:       alu = 16'h8000 | 16'($urandom_range(0, 255));
                default: alu = 16'($urandom);
            endcase
            drive(($urandom_range(0, 99) != 0), ex, alu, 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), fl, bv, ccc);
        end
        idle(0, 3'd0);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
